// File: rtl/pc_unit.sv
// Program counter unit: increment, two-byte absolute jump and
// pc-relative branch with a one-cycle high-byte fixup on page cross.
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        cmd_ready,
  output logic [15:0] pc,
  output logic        busy,
  output logic        page_cross
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_LO,
    S_LOAD_HI,
    S_FIXUP
  } state_t;

  localparam logic [1:0] C_INC    = 2'b00;
  localparam logic [1:0] C_JMP    = 2'b01;
  localparam logic [1:0] C_BRANCH = 2'b10;
  localparam logic [1:0] C_HOLD   = 2'b11;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_temp;
  logic        r_neg;
  logic        r_busy;
  logic        r_ready;
  logic        r_page_cross;

  logic        w_accept;
  logic [8:0]  w_sum;
  logic [15:0] w_tgt;
  logic        w_cross;

  // Branch target and page-cross detection from the offered offset
  always_comb begin
    w_accept = cmd_valid && r_ready;
    w_sum    = {1'b0, r_pc[7:0]} + {1'b0, din};
    w_tgt    = r_pc + {{8{din[7]}}, din};
    w_cross  = (w_tgt[15:8] != r_pc[15:8]);
  end

  // Command FSM with registered pc and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_temp       <= 8'h00;
      r_neg        <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b1;
      r_page_cross <= 1'b0;
    end else begin
      r_page_cross <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            unique case (cmd)
              C_INC: r_pc <= r_pc + 16'd1;
              C_JMP: begin
                r_state <= S_LOAD_LO;
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
              end
              C_BRANCH: begin
                if (w_cross) begin
                  r_pc[7:0]    <= w_sum[7:0];
                  r_neg        <= din[7];
                  r_state      <= S_FIXUP;
                  r_busy       <= 1'b1;
                  r_ready      <= 1'b0;
                  r_page_cross <= 1'b1;
                end else begin
                  r_pc <= w_tgt;
                end
              end
              C_HOLD: r_pc <= r_pc;
            endcase
          end
        end
        S_LOAD_LO: begin
          if (din_valid) begin
            r_temp  <= din;
            r_state <= S_LOAD_HI;
          end
        end
        S_LOAD_HI: begin
          if (din_valid) begin
            r_pc    <= {din, r_temp};
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        S_FIXUP: begin
          if (r_neg) r_pc[15:8] <= r_pc[15:8] - 8'd1;
          else       r_pc[15:8] <= r_pc[15:8] + 8'd1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign busy       = r_busy;
  assign cmd_ready  = r_ready;
  assign page_cross = r_page_cross;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_pc_unit;

  localparam logic [15:0] RST_PC = 16'hFFFC;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [7:0]  din;
  logic        din_valid;
  logic        cmd_ready;
  logic [15:0] pc;
  logic        busy;
  logic        page_cross;

  int n_pass;
  int n_total;

  pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .din        (din),
    .din_valid  (din_valid),
    .cmd_ready  (cmd_ready),
    .pc         (pc),
    .busy       (busy),
    .page_cross (page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 wants low byte,
  // 2 wants high byte, 3 finishing a page-crossing branch.
  int m_pc;
  int m_phase;
  int m_lo;
  int m_tgt;
  int m_pcross;

  function automatic void model(input logic r, input logic cv,
                                input logic [1:0] c,
                                input logic [7:0] d,
                                input logic dv);
    int off;
    int t;
    m_pcross = 0;
    if (r) begin
      m_pc    = RST_PC;
      m_phase = 0;
      m_lo    = 0;
      return;
    end
    case (m_phase)
      0: if (cv) begin
        case (c)
          2'b00: m_pc = (m_pc + 1) % 65536;
          2'b01: m_phase = 1;
          2'b10: begin
            off = (d >= 128) ? int'(d) - 256 : int'(d);
            t = (m_pc + off + 65536) % 65536;
            if ((t / 256) == (m_pc / 256)) begin
              m_pc = t;
            end else begin
              m_pc     = (m_pc / 256) * 256 + (t % 256);
              m_tgt    = t;
              m_phase  = 3;
              m_pcross = 1;
            end
          end
          default: ;
        endcase
      end
      1: if (dv) begin
        m_lo    = d;
        m_phase = 2;
      end
      2: if (dv) begin
        m_pc    = int'(d) * 256 + m_lo;
        m_phase = 0;
      end
      default: begin
        m_pc    = m_tgt;
        m_phase = 0;
      end
    endcase
  endfunction

  task automatic step(input logic r, input logic cv,
                      input logic [1:0] c, input logic [7:0] d,
                      input logic dv);
    rst       = r;
    cmd_valid = cv;
    cmd       = c;
    din       = d;
    din_valid = dv;
    @(posedge clk);
    model(r, cv, c, d, dv);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b11, 8'h00, 1'b0);
  endtask

  task automatic jmp_to(input logic [15:0] a);
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    step(1'b0, 1'b0, 2'b11, a[7:0], 1'b1);
    step(1'b0, 1'b0, 2'b11, a[15:8], 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'b00, 8'h55, 1'b1);
    n_total++;
    if (pc !== 16'hFFFC || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        page_cross !== 1'b0)
      $display("FAIL reset: pc=%h busy=%b rdy=%b pcx=%b want fffc 0 1 0",
               pc, busy, cmd_ready, page_cross);
    else n_pass++;
  endtask

  task automatic test_inc_wrap();
    jmp_to(16'hFFFF);
    n_total++;
    if (pc !== 16'hFFFF) $display("FAIL jmp_ffff: pc=%h want ffff", pc);
    else n_pass++;
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
    n_total++;
    if (pc !== 16'h0000) $display("FAIL inc_wrap: pc=%h want 0000", pc);
    else n_pass++;
    step(1'b0, 1'b1, 2'b11, 8'h00, 1'b1);
    n_total++;
    if (pc !== 16'h0000 || busy !== 1'b0)
      $display("FAIL hold: pc=%h busy=%b want 0000 0", pc, busy);
    else n_pass++;
  endtask

  task automatic test_jmp_gaps();
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    n_total++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || pc !== 16'h0000)
      $display("FAIL jmp_accept: busy=%b rdy=%b pc=%h want 1 0 0000",
               busy, cmd_ready, pc);
    else n_pass++;
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 2'b00, 8'h34, 1'b1);
    n_total++;
    if (busy !== 1'b1 || pc !== 16'h0000)
      $display("FAIL jmp_lo: busy=%b pc=%h want 1 0000", busy, pc);
    else n_pass++;
    step(1'b0, 1'b1, 2'b00, 8'h77, 1'b0);
    step(1'b0, 1'b1, 2'b10, 8'h77, 1'b0);
    n_total++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || pc !== 16'h0000)
      $display("FAIL jmp_gap: busy=%b rdy=%b pc=%h want 1 0 0000",
               busy, cmd_ready, pc);
    else n_pass++;
    step(1'b0, 1'b1, 2'b00, 8'h12, 1'b1);
    n_total++;
    if (pc !== 16'h1234 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL jmp_done: pc=%h busy=%b rdy=%b want 1234 0 1",
               pc, busy, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_branch_no_cross();
    jmp_to(16'h8010);
    step(1'b0, 1'b1, 2'b10, 8'hF0, 1'b0);
    n_total++;
    if (pc !== 16'h8000 || page_cross !== 1'b0 || busy !== 1'b0)
      $display("FAIL br_nocross: pc=%h pcx=%b busy=%b want 8000 0 0",
               pc, page_cross, busy);
    else n_pass++;
  endtask

  task automatic test_branch_cross();
    jmp_to(16'h80F0);
    step(1'b0, 1'b1, 2'b10, 8'h20, 1'b0);
    n_total++;
    if (pc !== 16'h8010 || page_cross !== 1'b1 || busy !== 1'b1)
      $display("FAIL br_fwd1: pc=%h pcx=%b busy=%b want 8010 1 1",
               pc, page_cross, busy);
    else n_pass++;
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1);
    n_total++;
    if (pc !== 16'h8110 || page_cross !== 1'b0 || busy !== 1'b0)
      $display("FAIL br_fwd2: pc=%h pcx=%b busy=%b want 8110 0 0",
               pc, page_cross, busy);
    else n_pass++;
    jmp_to(16'h8005);
    step(1'b0, 1'b1, 2'b10, 8'h80, 1'b0);
    n_total++;
    if (pc !== 16'h8085 || page_cross !== 1'b1)
      $display("FAIL br_back1: pc=%h pcx=%b want 8085 1", pc, page_cross);
    else n_pass++;
    idle();
    n_total++;
    if (pc !== 16'h7F85 || busy !== 1'b0)
      $display("FAIL br_back2: pc=%h busy=%b want 7f85 0", pc, busy);
    else n_pass++;
    jmp_to(16'hFFF0);
    step(1'b0, 1'b1, 2'b10, 8'h20, 1'b0);
    idle();
    n_total++;
    if (pc !== 16'h0010)
      $display("FAIL br_wrap: pc=%h want 0010", pc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    step(1'b0, 1'b0, 2'b11, 8'hAA, 1'b1);
    step(1'b1, 1'b1, 2'b00, 8'h55, 1'b1);
    n_total++;
    if (pc !== 16'hFFFC || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL rst_mid: pc=%h busy=%b rdy=%b want fffc 0 1",
               pc, busy, cmd_ready);
    else n_pass++;
    jmp_to(16'hC000);
    n_total++;
    if (pc !== 16'hC000)
      $display("FAIL rst_nostale: pc=%h want c000", pc);
    else n_pass++;
    jmp_to(16'h80F8);
    step(1'b0, 1'b1, 2'b10, 8'h10, 1'b0);
    step(1'b1, 1'b0, 2'b11, 8'h00, 1'b0);
    n_total++;
    if (pc !== 16'hFFFC || busy !== 1'b0 || page_cross !== 1'b0)
      $display("FAIL rst_fixup: pc=%h busy=%b pcx=%b want fffc 0 0",
               pc, busy, page_cross);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] snap;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom), 2'($urandom), 8'($urandom),
           ($urandom_range(0, 2) != 0));
      n_total++;
      if (pc !== 16'(m_pc) || busy !== (m_phase != 0) ||
          cmd_ready !== (m_phase == 0) || page_cross !== 1'(m_pcross))
        $display("FAIL rand[%0d]: pc=%h busy=%b rdy=%b pcx=%b want %h %b %b %b",
                 i, pc, busy, cmd_ready, page_cross, 16'(m_pc),
                 m_phase != 0, m_phase == 0, 1'(m_pcross));
      else n_pass++;
      if (i % 50 == 0) begin
        snap = pc;
        din_valid = 1'b1;
        cmd_valid = 1'b1;
        din = 8'($urandom);
        #3;
        n_total++;
        if (pc !== snap)
          $display("FAIL rand_stable[%0d]: pc=%h want %h", i, pc, snap);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'b11;
    din       = 8'h00;
    din_valid = 1'b0;
    m_pc      = RST_PC;
    m_phase   = 0;
    m_lo      = 0;
    m_tgt     = 0;
    m_pcross  = 0;
    test_reset();
    test_inc_wrap();
    test_jmp_gaps();
    test_branch_no_cross();
    test_branch_cross();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
